// File: rtl/mem_stage_ctrl.sv
// MEM-stage memory access controller.
// Turns pipeline load/store requests into single-beat requests on the backing-memory
// bus, stalls the pipeline while the bus is busy, and reports misaligned accesses and
// ack timeouts. Sub-word stores are lane-replicated and sub-word loads are extended.
module mem_stage_ctrl #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AlignErr,
   output logic        BusErr,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   output logic [3:0]  BusBe,
   input  logic        BusAck,
   input  logic [31:0] BusRData
);

   localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   // Counter value in the last REQ cycle that may still accept an ack
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              access_vld;
   logic              misaligned;
   logic [3:0]        be_nxt;
   logic [31:0]       wdata_nxt;

   logic              stall_c;
   logic              latch_en;
   logic              align_hit;
   logic              ack_hit;
   logic              timeout_hit;

   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt;

   // Select the addressed lane of a bus word and extend it to 32 bits.
   // Size 2'b11 falls into the word case.
   function automatic logic [31:0] load_extend(
      input logic [1:0]  size,
      input logic        sgn,
      input logic [1:0]  lane,
      input logic [31:0] word
   );
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b10: begin
            if (sgn) ext = b;
            else     ext = {24'd0, b};
         end
         2'b01: begin
            if (sgn) ext = h;
            else     ext = {16'd0, h};
         end
         default: ext = word;
      endcase
      return ext;
   endfunction

   // Decode the incoming request: alignment, byte enables and replicated store data
   always_comb begin
      access_vld = MemRead | MemWrite;
      misaligned = 1'b0;
      be_nxt     = 4'b1111;
      wdata_nxt  = WriteData;
      case (MemSize)
         2'b01: begin
            misaligned = Address[0];
            be_nxt     = Address[1] ? 4'b1100 : 4'b0011;
            wdata_nxt  = {2{WriteData[15:0]}};
         end
         2'b10: begin
            be_nxt    = 4'b0001 << Address[1:0];
            wdata_nxt = {4{WriteData[7:0]}};
         end
         default: misaligned = (Address[1:0] != 2'b00);
      endcase
   end

   // Next-state and per-cycle control; requests are only looked at in IDLE
   always_comb begin
      state_nxt   = state;
      stall_c     = 1'b0;
      BusReq      = 1'b0;
      latch_en    = 1'b0;
      align_hit   = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (access_vld) begin
               if (misaligned) begin
                  align_hit = 1'b1;
               end else begin
                  stall_c   = 1'b1;
                  latch_en  = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            BusReq  = 1'b1;
            stall_c = 1'b1;
            if (BusAck) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Reset must drop the stall at once, even while a request is presented in IDLE
   assign Stall    = stall_c & ~Reset;
   assign BusWe    = (state == REQ) & we_q;
   assign BusAddr  = {addr_q[31:2], 2'b00};
   assign BusWData = wdata_q;
   assign BusBe    = be_q;

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Capture the accepted access so the bus sees stable values for the whole request
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         we_q     <= 1'b0;
      end else if (latch_en) begin
         addr_q   <= Address;
         wdata_q  <= wdata_nxt;
         be_q     <= be_nxt;
         size_q   <= MemSize;
         signed_q <= MemSigned;
         we_q     <= MemWrite;
      end
   end

   // Count REQ cycles without an ack, restarting for every accepted access
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt <= '0;
      end else if (latch_en) begin
         cnt <= '0;
      end else if ((state == REQ) && !BusAck) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Error pulses and load result; a store completion leaves ReadData untouched
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         AlignErr <= 1'b0;
         BusErr   <= 1'b0;
         ReadData <= '0;
      end else begin
         AlignErr <= align_hit;
         BusErr   <= timeout_hit;
         if (align_hit || timeout_hit) begin
            ReadData <= '0;
         end else if (ack_hit && !we_q) begin
            ReadData <= load_extend(size_q, signed_q, addr_q[1:0], BusRData);
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized accesses,
// compared every cycle against a transaction-level reference model.
module tb_mem_stage_ctrl;

   localparam int TO = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  MemSize;
   logic        MemSigned;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        AlignErr;
   logic        BusErr;
   logic        BusReq;
   logic        BusWe;
   logic [31:0] BusAddr;
   logic [31:0] BusWData;
   logic [3:0]  BusBe;
   logic        BusAck;
   logic [31:0] BusRData;

   mem_stage_ctrl #(.ACK_TIMEOUT(TO)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemSize   (MemSize),
      .MemSigned (MemSigned),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .AlignErr  (AlignErr),
      .BusErr    (BusErr),
      .BusReq    (BusReq),
      .BusWe     (BusWe),
      .BusAddr   (BusAddr),
      .BusWData  (BusWData),
      .BusBe     (BusBe),
      .BusAck    (BusAck),
      .BusRData  (BusRData)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // expected outputs for the current cycle
   bit          chk_en = 1'b0;
   logic        e_stall, e_req, e_we, e_align, e_berr;
   logic [31:0] e_rdata, e_addr, e_wdata;
   logic [3:0]  e_be;
   bit          e_chk_bus, e_chk_wr;
   logic [31:0] m_rdata;

   int stall_seen = 0, busreq_seen = 0, align_seen = 0, berr_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sgn,
                                          input logic [31:0] addr, input logic [31:0] rd);
      logic [31:0] v;
      if (sz == 2'd2) begin
         v = (rd >> (8 * addr[1:0])) & 32'hFF;
         if (sgn && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2'd1) begin
         v = (rd >> (16 * addr[1])) & 32'hFFFF;
         if (sgn && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
      if (sz == 2'd2)      return 4'(32'd1 << addr[1:0]);
      else if (sz == 2'd1) return 4'(32'd3 << (addr[1:0] & 2'd2));
      else                 return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd2)      return (wd & 32'hFF) * 32'h0101_0101;
      else if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      else                 return wd;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("stall",     32'(Stall),    32'(e_stall));
         chk("bus_req",   32'(BusReq),   32'(e_req));
         chk("bus_we",    32'(BusWe),    32'(e_we));
         chk("align_err", 32'(AlignErr), 32'(e_align));
         chk("bus_err",   32'(BusErr),   32'(e_berr));
         chk("read_data", ReadData,      e_rdata);
         if (e_chk_bus) chk("bus_addr", BusAddr, e_addr);
         if (e_chk_wr) begin
            chk("bus_be",    32'(BusBe), 32'(e_be));
            chk("bus_wdata", BusWData,   e_wdata);
         end
         if (Stall)    stall_seen  <= stall_seen + 1;
         if (BusReq)   busreq_seen <= busreq_seen + 1;
         if (AlignErr) align_seen  <= align_seen + 1;
         if (BusErr)   berr_seen   <= berr_seen + 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic exp_idle();
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_align = 1'b0; e_berr = 1'b0;
      e_rdata = m_rdata; e_chk_bus = 1'b0; e_chk_wr = 1'b0;
   endtask

   task automatic exp_cleared();
      exp_idle();
      e_chk_bus = 1'b1; e_chk_wr = 1'b1; e_addr = '0; e_be = '0; e_wdata = '0;
   endtask

   task automatic quiet_inputs();
      MemRead = 1'b0; MemWrite = 1'b0;
      MemSize = 2'($urandom); MemSigned = 1'($urandom);
      Address = $urandom; WriteData = $urandom;
      BusAck = 1'($urandom); BusRData = $urandom;
   endtask

   task automatic idle_cycle();
      cyc(); quiet_inputs(); exp_idle();
   endtask

   // One pipeline access; ack_at = REQ cycle (1-based) carrying BusAck, anything else = never
   task automatic access(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rdata);
      logic [1:0] sz;
      bit valid, mis, acked;
      sz    = (size == 2'b11) ? 2'b00 : size;
      valid = rd | wr;
      mis   = (sz == 2'd0 && addr[1:0] != 2'd0) || (sz == 2'd1 && addr[0]);
      cyc();
      MemRead = rd; MemWrite = wr; MemSize = size; MemSigned = sgn;
      Address = addr; WriteData = wd;
      BusAck = 1'($urandom); BusRData = $urandom;
      exp_idle();
      e_stall = valid && !mis;
      if (!valid) return;
      if (mis) begin
         cyc(); quiet_inputs();
         m_rdata = '0;
         exp_idle(); e_align = 1'b1;
         return;
      end
      acked = 1'b0;
      for (int k = 1; k <= TO && !acked; k++) begin
         cyc();
         Address = $urandom; WriteData = $urandom;
         MemSize = 2'($urandom); MemSigned = 1'($urandom);
         BusAck = (k == ack_at);
         BusRData = (k == ack_at) ? rdata : $urandom;
         exp_idle();
         e_stall = 1'b1; e_req = 1'b1; e_we = wr;
         e_chk_bus = 1'b1; e_addr = addr & 32'hFFFF_FFFC;
         e_chk_wr = wr; e_be = m_be(sz, addr); e_wdata = m_wdata(sz, wd);
         acked = (k == ack_at);
      end
      // completion cycle: request still presented but must be ignored
      cyc();
      BusAck = 1'($urandom); BusRData = $urandom;
      if (!acked)  m_rdata = '0;
      else if (!wr) m_rdata = m_load(sz, sgn, addr, rdata);
      exp_idle(); e_berr = !acked;
      idle_cycle();
   endtask

   task automatic reset_mid_req();
      cyc();
      MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd0; MemSigned = 1'b0;
      Address = 32'h40; WriteData = $urandom; BusAck = 1'b0; BusRData = $urandom;
      exp_idle(); e_stall = 1'b1;
      cyc();
      BusAck = 1'b0;
      exp_idle(); e_stall = 1'b1; e_req = 1'b1; e_chk_bus = 1'b1; e_addr = 32'h40;
      cyc();
      BusAck = 1'b0;
      #1 Reset = 1'b1;
      m_rdata = '0;
      exp_cleared();
      cyc();
      Reset = 1'b0; quiet_inputs(); exp_cleared();
      cyc();
      quiet_inputs(); exp_cleared();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s0, r0, a0, b0;
      bit rd, wr, sgn;
      logic [1:0] size;
      logic [31:0] addr;

      Reset = 1'b1; m_rdata = '0;
      MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd0; MemSigned = 1'b0;
      Address = 32'h10; WriteData = '0; BusAck = 1'b0; BusRData = '0;
      exp_cleared();

      // model pins
      chk("pin_load_sbyte", m_load(2'd2, 1'b1, 32'h13, 32'h8000_0000), 32'hFFFF_FF80);
      chk("pin_load_ubyte", m_load(2'd2, 1'b0, 32'h13, 32'h8000_0000), 32'h0000_0080);
      chk("pin_be_half",    32'(m_be(2'd1, 32'h22)), 32'h0000_000C);
      chk("pin_wdata_half", m_wdata(2'd1, 32'h0000_1234), 32'h1234_1234);

      // reset state, with a request presented during reset
      cyc(); exp_cleared(); chk_en = 1'b1;
      cyc(); Reset = 1'b0; quiet_inputs(); exp_cleared();

      // word load, ack in the third REQ cycle
      s0 = stall_seen;
      access(1, 0, 2'd0, 0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF);
      idle_cycle();
      chk("t_word_stall_cycles", 32'(stall_seen - s0), 32'd4);
      chk("t_word_rdata", ReadData, 32'hDEAD_BEEF);

      // misaligned word load
      s0 = stall_seen; r0 = busreq_seen; a0 = align_seen;
      access(1, 0, 2'd0, 0, 32'h06, 32'h0, 1, 32'h1111_1111);
      idle_cycle();
      chk("t_mis_align_pulses", 32'(align_seen - a0), 32'd1);
      chk("t_mis_stall_cycles", 32'(stall_seen - s0), 32'd0);
      chk("t_mis_busreq_cycles", 32'(busreq_seen - r0), 32'd0);
      chk("t_mis_rdata", ReadData, 32'h0);

      // signed / unsigned byte loads from lane 3
      access(1, 0, 2'd2, 1, 32'h13, 32'h0, 1, 32'h8000_0000);
      idle_cycle();
      chk("t_sbyte_rdata", ReadData, 32'hFFFF_FF80);
      access(1, 0, 2'd2, 0, 32'h13, 32'h0, 2, 32'h8000_0000);
      idle_cycle();
      chk("t_ubyte_rdata", ReadData, 32'h0000_0080);

      // half store to the upper half; ReadData must not change
      access(0, 1, 2'd1, 0, 32'h22, 32'h0000_1234, 1, 32'h5555_5555);
      idle_cycle();
      chk("t_hstore_rdata_kept", ReadData, 32'h0000_0080);

      // ack never arrives
      r0 = busreq_seen; b0 = berr_seen;
      access(1, 0, 2'd0, 0, 32'h30, 32'h0, 0, 32'h0);
      idle_cycle();
      chk("t_timeout_busreq_cycles", 32'(busreq_seen - r0), 32'd4);
      chk("t_timeout_buserr_pulses", 32'(berr_seen - b0), 32'd1);
      chk("t_timeout_rdata", ReadData, 32'h0);

      // reset in the middle of a request, then a normal access
      access(1, 0, 2'd0, 0, 32'h50, 32'h0, 1, 32'h0BAD_CAFE);
      reset_mid_req();
      access(1, 0, 2'd0, 0, 32'h44, 32'h0, 1, 32'hCAFE_F00D);
      idle_cycle();
      chk("t_after_reset_rdata", ReadData, 32'hCAFE_F00D);

      // randomized accesses
      for (int n = 0; n < 250; n++) begin
         rd   = 1'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         size = 2'($urandom);
         sgn  = 1'($urandom);
         addr = $urandom;
         if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
         access(rd, wr, size, sgn, addr, $urandom, $urandom_range(0, 5), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();
      idle_cycle();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: maximum cycles spent in REQ state without BusAck before abort.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  MEM-stage load request.
REQ-005 MemWrite  input  1  MEM-stage store request.
REQ-006 MemSize  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 MemSigned  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-008 Address  input  32  byte address from EX/MEM ALU result.
REQ-009 WriteData  input  32  store data, right-justified.
REQ-010 ReadData  output  32  load result, valid in DONE cycle, held until next DONE or reset.
REQ-011 Stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
REQ-012 AlignErr  output  1  one-cycle pulse on misaligned access.
REQ-013 BusErr  output  1  one-cycle pulse on ack timeout.
REQ-014 BusReq, BusWe  output  1 each  backing-memory request and write strobe.
REQ-015 BusAddr  output  32  word-aligned address ({Address[31:2],2'b00}).
REQ-016 BusWData  output  32, BusBe  output  4  lane-replicated store data and byte enables.
REQ-017 BusAck  input  1, BusRData  input  32  backing-memory completion and read word.

Function
REQ-018 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-019 IDLE: access valid when MemRead|MemWrite; MemWrite has priority if both high (access is a store).
REQ-020 Misaligned = word with Address[1:0]!=0, or half with Address[0]=1; byte never misaligned.
REQ-021 IDLE + valid aligned access: Stall=1 combinationally that cycle; latch address, data, size, signed, we; next state REQ.
REQ-022 IDLE + valid misaligned access: no bus request, AlignErr=1 next cycle for one cycle, ReadData<=0, Stall=0, remain IDLE.
REQ-023 REQ: BusReq=1, Stall=1; BusAddr/BusWe/BusWData/BusBe driven from latched values and stable until ack.
REQ-024 REQ + BusAck sampled high: load -> ReadData registered from BusRData; next state DONE; BusReq drops the following cycle.
REQ-025 Lanes little-endian: byte lane = Address[1:0], half lane = Address[1]; byte store BusWData={4{b}}, BusBe=0001<<Address[1:0]; half BusWData={2{h}}, BusBe=0011<<(2*Address[1]); word BusBe=1111.
REQ-026 Sub-word loads extract selected lane, extend per MemSigned to 32 bits; stores leave ReadData unchanged.
REQ-027 Cycle counter cleared on entering REQ; increments each REQ cycle without ack; at ACK_TIMEOUT: BusReq drops, BusErr pulses one cycle, ReadData<=0, next state DONE.
REQ-028 DONE: Stall=0, BusReq=0 for exactly one cycle (pipeline advances on this edge); unconditional return to IDLE; requests seen in DONE ignored.
REQ-029 Minimum access latency: request cycle + 1 REQ cycle + DONE = Stall high 2 cycles with same-cycle ack.
REQ-030 BusAck outside REQ state is ignored.

Reset
REQ-031 Reset asserted at any time (including mid-REQ) forces immediately: state IDLE, BusReq=0, BusWe=0, Stall=0, AlignErr=0, BusErr=0, ReadData=0, BusBe=0, BusAddr=0, BusWData=0, counter=0.
REQ-032 First request after deassertion handled normally; no stale latched access replayed.

Verification
REQ-033 Word load Address=0x0000_0010, BusAck after 3 REQ cycles, BusRData=0xDEAD_BEEF -> BusAddr=0x10, Stall high 4 cycles, ReadData=0xDEAD_BEEF in DONE.
REQ-034 Signed byte load Address=0x13, BusRData=0x80_00_00_00 -> BusBe irrelevant, ReadData=0xFFFF_FF80; same with MemSigned=0 -> 0x0000_0080.
REQ-035 Half store Address=0x22, WriteData=0x0000_1234 -> BusWe=1, BusBe=1100, BusWData=0x1234_1234, BusAddr=0x20.
REQ-036 Word load Address=0x06 -> no BusReq, AlignErr one pulse, Stall never high, ReadData=0.
REQ-037 ACK_TIMEOUT=4, BusAck never asserted -> BusReq high 4 cycles, BusErr pulse, DONE, ReadData=0, back to IDLE.
REQ-038 Reset asserted in second REQ cycle -> BusReq and Stall low same cycle; next valid request completes normally.
